// File: rtl/fir_out_decim_buf.sv
// FIR output stage: drops fill samples, decimates, rounds/saturates and buffers in a FWFT FIFO.
// Latency: 2 edges from din to m_valid; when the FIFO is full with no pop, the sample is dropped and ovf_sticky is set.
module fir_out_decim_buf #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 4,
  parameter int DECIM  = 2,
  parameter int WARMUP = 37,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [IN_W-1:0]     din,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [OUT_W-1:0]    m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_sticky,
  output logic                       ovf_sticky,
  input  logic                       clr
);
  localparam int XW = IN_W + 1;
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CW-1:0] WARM_LAST  = CW'((WARMUP >= 2) ? WARMUP - 2 : 0);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'((DECIM > 1) ? 1 : 0);

  localparam logic signed [XW-1:0] RND  = XW'(2 ** (SHIFT - 1));
  localparam logic signed [XW-1:0] MAXV = XW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] MINV = XW'(-(2 ** (OUT_W - 1)));
  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    warm_cnt, warm_cnt_nxt;
  logic [PW-1:0]    phase, phase_nxt;
  logic             keep;

  logic signed [XW-1:0]    q_sum, q_r;
  logic                    sat_hi, sat_lo;
  logic signed [OUT_W-1:0] q_val;
  logic                    q_vld;
  logic [OUT_W-1:0]        q_dat;
  logic                    fifo_wr_rdy;
  logic [OUT_W-1:0]        fifo_rd_dat;

  // The en-rising edge already discards one sample, so WARM exits after WARMUP-1 more.
  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    phase_nxt    = phase;
    keep         = 1'b0;
    if (!en) begin
      state_nxt    = IDLE;
      warm_cnt_nxt = '0;
      phase_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          warm_cnt_nxt = '0;
          phase_nxt    = '0;
          if (WARMUP == 0) begin
            state_nxt = RUN;
            keep      = 1'b1;
            phase_nxt = PHASE_ONE;
          end else if (WARMUP == 1) begin
            state_nxt = RUN;
          end else begin
            state_nxt = WARM;
          end
        end
        WARM: begin
          if (warm_cnt == WARM_LAST) begin
            state_nxt = RUN;
            phase_nxt = '0;
          end else begin
            warm_cnt_nxt = warm_cnt + 1'b1;
          end
        end
        RUN: begin
          keep      = (phase == '0);
          phase_nxt = (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    q_sum  = $signed({din[IN_W-1], din}) + RND;
    q_r    = q_sum >>> SHIFT;
    sat_hi = (q_r > MAXV);
    sat_lo = (q_r < MINV);
    if (sat_hi)      q_val = OMAX;
    else if (sat_lo) q_val = OMIN;
    else             q_val = q_r[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      warm_cnt <= '0;
      phase    <= '0;
      q_vld    <= 1'b0;
      q_dat    <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      phase    <= phase_nxt;
      q_vld    <= keep;
      if (keep) q_dat <= q_val;
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (keep && (sat_hi || sat_lo)) sat_sticky <= 1'b1;
      else if (clr)                   sat_sticky <= 1'b0;
      if (q_vld && !fifo_wr_rdy)      ovf_sticky <= 1'b1;
      else if (clr)                   ovf_sticky <= 1'b0;
    end
  end

  sync_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (q_vld),
    .wr_dat (q_dat),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (m_valid),
    .rd_rdy (m_ready),
    .rd_dat (fifo_rd_dat),
    .level  (level)
  );

  assign m_data = fifo_rd_dat;
endmodule

// Generic first-word fall-through FIFO; head is visible combinationally, zero when empty.
// A write into a full FIFO is accepted only when a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [W-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign rd_vld = (level != '0);
  assign pop    = rd_vld & rd_rdy;
  assign wr_rdy = (level != LW'(DEPTH)) | pop;
  assign push   = wr_vld & wr_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule
